// File: rtl/chop_pkg.sv
// Shared constants, state encoding and config bundle for chop_ctrl.
// Optional feature macro: CHOP_CTRL_PERIOD_LIMIT_EN (see chop_ctrl.sv).
package chop_pkg;

  localparam int W = 32;

  localparam logic [W-1:0] DEF_CHANGE = 32'd1000;
  localparam logic [W-1:0] DEF_MAX    = 32'd2000;
  localparam logic [W-1:0] MIN_MAX    = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_RUN       = 2'd2,
    ST_STOP_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic [W-1:0] change;
    logic [W-1:0] max;
    logic         dflt;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    change: DEF_CHANGE,
    max:    DEF_MAX,
    dflt:   1'b0
  };

  // A period needs room for both phases: change strictly inside (0, max).
  function automatic logic cfg_legal(input cfg_t c);
    return (c.max >= MIN_MAX) &&
           (c.change != '0) &&
           (c.change < c.max);
  endfunction

endpackage

// File: rtl/chop_cfg_shadow.sv
// Config shadow: validates host writes, holds pending timing
// and swaps it into the active set at chop-period boundaries.
module chop_cfg_shadow
  import chop_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_i,
  input  cfg_t wr_cfg_i,
  input  logic running_i,
  input  logic wrap_i,
  output cfg_t act_o,
  output logic pend_o,
  output logic err_o
);

  cfg_t act_q, act_d;
  cfg_t pnd_q, pnd_d;
  logic pend_q, pend_d;
  logic err_q, err_d;

  // Boundary swap first, so a write in the wrap cycle waits a period.
  always_comb begin
    act_d  = act_q;
    pnd_d  = pnd_q;
    pend_d = pend_q;
    err_d  = err_q;
    // a write caught on the run's final wrap lands once idle
    if (pend_q && (wrap_i || !running_i)) begin
      act_d  = pnd_q;
      pend_d = 1'b0;
    end
    if (wr_i) begin
      if (!cfg_legal(wr_cfg_i)) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
        if (running_i) begin
          pnd_d  = wr_cfg_i;
          pend_d = 1'b1;
        end else begin
          act_d = wr_cfg_i;
        end
      end
    end
  end

  // Shadow/active register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= CFG_RST;
      pnd_q  <= CFG_RST;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      pnd_q  <= pnd_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign act_o  = act_q;
  assign pend_o = pend_q;
  assign err_o  = err_q;

endmodule

// File: rtl/chop_ctrl.sv
// Chopper sequencing controller: arm/trigger/stop FSM, phase and
// period counters. Macro CHOP_CTRL_PERIOD_LIMIT_EN adds a period limit.
module chop_ctrl
  import chop_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_wr_i,
  input  logic [W-1:0] cfg_change_i,
  input  logic [W-1:0] cfg_max_i,
  input  logic         cfg_default_i,
  input  logic         arm_i,
  input  logic         trig_i,
  input  logic         stop_i,
  input  logic [W-1:0] n_periods_i,
  output logic         chop_en_o,
  output logic         chop_default_o,
  output logic [W-1:0] change_count_o,
  output logic [W-1:0] max_count_o,
  output logic [W-1:0] period_cnt_o,
  output logic [1:0]   state_o,
  output logic         cfg_pend_o,
  output logic         cfg_err_o
);

  state_e       state_q, state_d;
  logic [W-1:0] phase_q, phase_d;
  logic [W-1:0] per_q, per_d;
  logic         trig_q;
  logic         en_q, en_d;
  logic         trig_edge;
  logic         running;
  logic         wrap;
  logic         limit_hit;
  cfg_t         wr_cfg;
  cfg_t         act;

  assign wr_cfg.change = cfg_change_i;
  assign wr_cfg.max    = cfg_max_i;
  assign wr_cfg.dflt   = cfg_default_i;

  chop_cfg_shadow u_shadow (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (cfg_wr_i),
    .wr_cfg_i (wr_cfg),
    .running_i(running),
    .wrap_i   (wrap),
    .act_o    (act),
    .pend_o   (cfg_pend_o),
    .err_o    (cfg_err_o)
  );

  assign trig_edge = trig_i & ~trig_q;
  assign running   = (state_q == ST_RUN) ||
                     (state_q == ST_STOP_WAIT);
  assign wrap      = running &&
                     (phase_q == act.max - 1'b1);

  // Next state, phase and period count.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    per_d     = per_q;
    limit_hit = 1'b0;
    if (running) begin
      phase_d = wrap ? '0 : phase_q + 1'b1;
    end
    if (wrap && (per_q != '1)) begin
      per_d = per_q + 1'b1;
    end
`ifdef CHOP_CTRL_PERIOD_LIMIT_EN
    limit_hit = wrap && (n_periods_i != '0) &&
                (per_d == n_periods_i);
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (trig_edge) begin
          state_d = ST_RUN;
          phase_d = '0;
          per_d   = '0;
        end
      end
      ST_RUN: begin
        if (limit_hit)   state_d = ST_IDLE;
        else if (stop_i) state_d = ST_STOP_WAIT;
      end
      ST_STOP_WAIT: begin
        if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    en_d = (state_d == ST_RUN) ||
           (state_d == ST_STOP_WAIT);
  end

`ifndef CHOP_CTRL_PERIOD_LIMIT_EN
  logic unused_n_periods;
  assign unused_n_periods = ^n_periods_i;
`endif

  // FSM, counters, trigger history and registered enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      per_q   <= '0;
      trig_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      trig_q  <= trig_i;
      en_q    <= en_d;
    end
  end

  assign chop_en_o      = en_q;
  assign chop_default_o = act.dflt;
  assign change_count_o = act.change;
  assign max_count_o    = act.max;
  assign period_cnt_o   = per_q;
  assign state_o        = state_q;

endmodule

// File: doc/chop_ctrl.md
Name: chop_ctrl

Overview:
- Sequencing/configuration controller for the chopper generator (chop_gen) in the W7-X interlock front end.
- Holds host-written chop timing (change_count, max_count, chop_default) in shadow registers and applies them only at chop-period boundaries.
- Arms on host command, starts on an external trigger edge and stops cleanly at the end of the current period.
- Drives chop_gen's chop_en/chop_default/change_count/max_count inputs and reports run status and the period count.

Parameters:
W, 32, width of count fields
DEF_CHANGE, 1000, reset value of active change_count
DEF_MAX, 2000, reset value of active max_count
MIN_MAX, 4, smallest legal max_count

Ports:
clk  input  1  system clock (ADC word-sync domain)
rst  input  1  asynchronous, active-high reset
cfg_wr_i  input  1  one-cycle config write strobe
cfg_change_i  input  W  requested change_count
cfg_max_i  input  W  requested max_count
cfg_default_i  input  1  requested chop_default
arm_i  input  1  arm request, level sampled each cycle
trig_i  input  1  start trigger, already synchronous; rising edge used
stop_i  input  1  stop request, level
n_periods_i  input  W  period limit (used only with CHOP_CTRL_PERIOD_LIMIT_EN)
chop_en_o  output  1  to chop_gen.chop_en
chop_default_o  output  1  active chop_default
change_count_o  output  W  active change_count
max_count_o  output  W  active max_count
period_cnt_o  output  W  completed periods since start, saturating
state_o  output  2  FSM state code
cfg_pend_o  output  1  shadow config waiting for boundary
cfg_err_o  output  1  sticky: last write rejected

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high. All outputs are registered.
- Reset values:
  - State IDLE; chop_en_o=0, chop_default_o=0.
  - change_count_o=DEF_CHANGE, max_count_o=DEF_MAX.
  - period_cnt_o=0, cfg_pend_o=0, cfg_err_o=0.
  - Phase counter=0; trig edge register=0.
- Reset mid-RUN drops chop_en_o immediately (asynchronously).
- Validation (unsigned): a write is legal iff cfg_max_i>=MIN_MAX and 0<cfg_change_i<cfg_max_i.
  - Illegal write: cfg_err_o=1 next cycle; shadow and active registers unchanged.
  - Legal write: clears cfg_err_o.
- Applying a legal write:
  - In IDLE or ARMED: copied to the active registers next cycle; cfg_pend_o stays 0.
  - In RUN or STOP_WAIT: stored in the pending register with cfg_pend_o=1.
  - A later legal write overwrites the pending value.
- Phase counter (W bits):
  - Cleared on entry to RUN.
  - Increments each cycle in RUN/STOP_WAIT.
  - Wrap = (phase == max_count_o-1); the counter returns to 0 on wrap.
- At wrap:
  - Pending config is copied to the active registers and cfg_pend_o clears.
  - period_cnt_o increments, saturating at 2^W-1.
  - A cfg_wr_i in the same cycle as a wrap becomes pending for the next wrap, not the current one.
- FSM (state_o: IDLE=0, ARMED=1, RUN=2, STOP_WAIT=3):
  - IDLE→ARMED when arm_i=1.
  - ARMED→IDLE when stop_i=1. If stop_i and a trig edge occur together, stop wins.
  - ARMED→RUN on a trig_i rising edge. period_cnt_o clears and phase clears.
  - RUN→STOP_WAIT when stop_i=1.
  - STOP_WAIT→IDLE on the next wrap, so the final period always completes.
  - A stop_i asserted in RUN on a wrap cycle still waits for the following wrap.
- Trig edge latency: an edge sampled at cycle k gives state_o=RUN and chop_en_o=1 at k+1.
- chop_en_o=1 only in RUN and STOP_WAIT. It returns to 0 the cycle after the terminating wrap.
- A trig_i edge in IDLE, RUN or STOP_WAIT is ignored.
- arm_i is ignored outside IDLE.

Optional Feature:
- Macro: CHOP_CTRL_PERIOD_LIMIT_EN.
- Defined: in RUN, a wrap that brings period_cnt_o to n_periods_i forces a transition to IDLE directly, with chop_en_o=0 the next cycle. n_periods_i=0 means unlimited.
- Undefined: n_periods_i is ignored and the run ends only via stop_i.

Decomposition:
- Package chop_pkg holds:
  - Constants: W, DEF_CHANGE, DEF_MAX, MIN_MAX.
  - The 2-bit state enum/localparams.
  - A struct/bundle {change, max, dflt} for config.
- One sub-module, chop_cfg_shadow, contains:
  - Legality check, pending register and cfg_err/cfg_pend flags.
  - Inputs: write strobe, a "running" flag and the wrap pulse.
  - Output: active config.
- The FSM and counters stay in chop_ctrl.

Test Plan:
- Reset then idle: outputs 1000/2000/0, state 0, chop_en_o=0. Assert rst for 3 cycles mid-RUN → chop_en_o=0 immediately and state 0.
- arm_i pulse, trig_i rises at cycle k → state 2 and chop_en_o=1 at k+1. With max=2000, period_cnt_o=1 after 2000 cycles and 3 after 6000 cycles.
- In RUN, write change=300/max=500 at phase 10 → cfg_pend_o=1 and outputs still 1000/2000. At the wrap, outputs become 300/500; the next wrap follows 500 cycles later.
- Illegal writes: change=600/max=500 → cfg_err_o=1, outputs unchanged. max=3 → cfg_err_o=1. Then a legal 10/20 write → cfg_err_o=0.
- stop_i at phase 100 of a 2000-cycle period → state 3 until the wrap 1900 cycles later, then state 0 and chop_en_o=0. In ARMED, stop_i together with a trig edge → IDLE, no run.
- With CHOP_CTRL_PERIOD_LIMIT_EN, n_periods_i=3, max=20 → chop_en_o is high for exactly 60 cycles and period_cnt_o=3 at the end. With n_periods_i=0 the run continues until stop_i.
